// File: rtl/mem_arb_2p.sv
// Shares one single-port word memory between the fetch port and the load/store port.
// One transaction at a time: latch in IDLE, hold address for WAIT_CYCLES, ack in RESP.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here
// ACCESS | memory address held; cnt counts down to the capture/commit cycle
// RESP   | one-cycle ack to the grantee
module mem_arb_2p #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [11:2] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [11:2] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [11:2] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        sel_d, sel_d_nx;
   logic        last_d, last_d_nx;
   logic        we_q, we_nx;
   logic        grant_d;
   logic [11:2] addr_nx;
   logic [31:0] wdata_nx;
   logic        mem_we_nx;
   logic        cap_if, cap_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      sel_d_nx  = sel_d;
      last_d_nx = last_d;
      we_nx     = we_q;
      addr_nx   = mem_addr;
      wdata_nx  = mem_wdata;
      mem_we_nx = 1'b0;
      cap_if    = 1'b0;
      cap_d     = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               // on a tie the port that lost last time wins
               grant_d   = d_req && (!if_req || !last_d);
               sel_d_nx  = grant_d;
               last_d_nx = grant_d;
               we_nx     = grant_d && d_we;
               addr_nx   = grant_d ? d_addr : if_addr;
               wdata_nx  = grant_d ? d_wdata : mem_wdata;
               cnt_nx    = CNT_INIT;
               mem_we_nx = grant_d && d_we && (CNT_INIT == 4'd0);
               state_nx  = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt != 4'd0) begin
               cnt_nx    = cnt - 4'd1;
               mem_we_nx = we_q && (cnt == 4'd1);
            end else begin
               cap_if   = !sel_d;
               cap_d    = sel_d && !we_q;
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 4'd0;
         sel_d     <= 1'b0;
         last_d    <= 1'b1;
         we_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         cnt       <= cnt_nx;
         sel_d     <= sel_d_nx;
         last_d    <= last_d_nx;
         we_q      <= we_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
         mem_we    <= mem_we_nx;
         if (cap_if) if_rdata <= mem_rdata;
         if (cap_d)  d_rdata  <= mem_rdata;
      end
   end

   assign if_ack = (state == RESP) && !sel_d;
   assign d_ack  = (state == RESP) && sel_d;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arb_2p.sv
// Bench for mem_arb_2p: behavioural memory, scoreboard of expected acks and read data,
// plus a second instance with WAIT_CYCLES = 4 for the long-access case.
module tb_mem_arb_2p;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'hA5000000 ^ (32'(i) * 32'h00010003);
   endfunction

   // WAIT_CYCLES = 1 instance
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [11:2] if_addr = '0, d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        if_ack, d_ack, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [11:2] mem_addr;
   logic [31:0] mem1 [1024];

   mem_arb_2p #(.WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   assign mem_rdata = mem1[mem_addr];
   initial begin
      for (int i = 0; i < 1024; i++) mem1[i] = pat(i);
      forever begin
         @(posedge clk);
         if (mem_we) mem1[mem_addr] = mem_wdata;
      end
   end

   // WAIT_CYCLES = 4 instance
   logic        w4_if_req = 1'b0, w4_d_req = 1'b0, w4_d_we = 1'b0;
   logic [11:2] w4_if_addr = '0, w4_d_addr = '0;
   logic [31:0] w4_d_wdata = '0;
   logic        w4_if_ack, w4_d_ack, w4_mem_we, w4_busy;
   logic [31:0] w4_if_rdata, w4_d_rdata, w4_mem_wdata, w4_mem_rdata;
   logic [11:2] w4_mem_addr;
   logic [31:0] mem4 [1024];

   mem_arb_2p #(.WAIT_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .if_req(w4_if_req), .if_addr(w4_if_addr), .if_ack(w4_if_ack), .if_rdata(w4_if_rdata),
      .d_req(w4_d_req), .d_we(w4_d_we), .d_addr(w4_d_addr), .d_wdata(w4_d_wdata),
      .d_ack(w4_d_ack), .d_rdata(w4_d_rdata),
      .mem_addr(w4_mem_addr), .mem_we(w4_mem_we), .mem_wdata(w4_mem_wdata),
      .mem_rdata(w4_mem_rdata), .busy(w4_busy)
   );

   assign w4_mem_rdata = mem4[w4_mem_addr];
   initial begin
      for (int i = 0; i < 1024; i++) mem4[i] = pat(i);
      forever begin
         @(posedge clk);
         if (w4_mem_we) mem4[w4_mem_addr] = w4_mem_wdata;
      end
   end

   // scoreboard: expected grantee and both rdata registers at each ack
   typedef struct {
      bit          port;
      logic [31:0] ifv;
      logic [31:0] dv;
   } exp_t;
   exp_t        sbq[$];
   logic [31:0] ref_mem [1024];
   logic [31:0] m_if = '0, m_d = '0;
   int          ack_cnt = 0, we_cyc = 0, busy_cyc = 0;
   logic        prev_ack = 1'b0;

   function automatic void push_exp(input bit port, input bit we, input logic [9:0] a,
                                    input logic [31:0] wd);
      if (!port) m_if = ref_mem[a];
      else if (we) ref_mem[a] = wd;
      else m_d = ref_mem[a];
      sbq.push_back('{port, m_if, m_d});
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ack = 1'b0;
         end else begin
            chk("ack_excl", 32'(if_ack & d_ack), 32'd0);
            chk("ack_b2b", 32'(prev_ack & (if_ack | d_ack)), 32'd0);
            prev_ack = if_ack | d_ack;
            if (mem_we) we_cyc++;
            if (busy) busy_cyc++;
            if (if_ack || d_ack) begin
               ack_cnt++;
               chk("unexp_ack", 32'(sbq.size() == 0), 32'd0);
               if (sbq.size() != 0) begin
                  e = sbq.pop_front();
                  chk("ack_port", 32'(d_ack), 32'(e.port));
                  chk("if_rdata", if_rdata, e.ifv);
                  chk("d_rdata", d_rdata, e.dv);
               end
            end
         end
      end
   end

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input bit port, input bit we, input logic [9:0] a, input logic [31:0] wd);
      int n;
      push_exp(port, we, a, wd);
      @(negedge clk);
      if (port) begin
         d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      @(posedge clk);
      n = 1;
      @(negedge clk);
      while (!(port ? d_ack : if_ack) && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("latency", 32'(n), 32'd2);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask

   initial begin
      int   a0;
      time  tp, t;
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);

      // reset values
      #1;
      chk("rst_if_ack", 32'(if_ack), 32'd0);
      chk("rst_d_ack", 32'(d_ack), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      settle();

      // fetch at 0x10
      busy_cyc = 0;
      xfer(1'b0, 1'b0, 10'h010, 32'd0);
      settle();
      chk("fetch_busy_cycles", 32'(busy_cyc), 32'd2);

      // store then load at 0x20
      we_cyc = 0;
      xfer(1'b1, 1'b1, 10'h020, 32'h12345678);
      settle();
      chk("store_we_cycles", 32'(we_cyc), 32'd1);
      chk("store_mem_word", mem1[32], 32'h12345678);
      xfer(1'b1, 1'b0, 10'h020, 32'd0);
      settle();

      // long access on the WAIT_CYCLES = 4 instance, top word
      @(negedge clk);
      w4_d_req = 1'b1; w4_d_we = 1'b0; w4_d_addr = 10'h3FF;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("w4_addr_hold", 32'(w4_mem_addr), 32'h3FF);
         chk("w4_no_early_ack", 32'(w4_d_ack), 32'd0);
      end
      @(negedge clk);
      chk("w4_d_ack", 32'(w4_d_ack), 32'd1);
      chk("w4_d_rdata", w4_d_rdata, pat(1023));
      w4_d_req = 1'b0;
      @(negedge clk);
      chk("w4_ack_pulse", 32'(w4_d_ack), 32'd0);
      settle();

      // both ports held from reset: grants must alternate I, D, I, D
      @(negedge clk);
      rst_n = 1'b0;
      m_if = '0; m_d = '0;
      if_addr = 10'h030; d_addr = 10'h040; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      push_exp(1'b0, 1'b0, 10'h030, 32'd0);
      push_exp(1'b1, 1'b0, 10'h040, 32'd0);
      push_exp(1'b0, 1'b0, 10'h030, 32'd0);
      push_exp(1'b1, 1'b0, 10'h040, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tp = 0;
      for (int k = 0; k < 4; k++) begin
         int w;
         w = 0;
         @(negedge clk);
         while (!(if_ack || d_ack) && w < 40) begin
            @(negedge clk);
            w++;
         end
         chk("arb_ack_seen", 32'(if_ack | d_ack), 32'd1);
         t = $time;
         if (k > 0) chk("arb_period", 32'((t - tp) / 10), 32'd3);
         tp = t;
         if (k == 3) begin
            if_req = 1'b0; d_req = 1'b0;
         end else begin
            if (d_ack) d_req = 1'b0;
            else if_req = 1'b0;
            @(negedge clk);
            if_req = 1'b1; d_req = 1'b1;
         end
      end
      settle();

      // reset during the ACCESS cycle of a store
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 10'h050; d_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      chk("abort_we_before", 32'(mem_we), 32'd1);
      a0 = ack_cnt;
      rst_n = 1'b0;
      d_req = 1'b0; d_we = 1'b0;
      m_if = '0; m_d = '0;
      #1;
      chk("abort_we_async", 32'(mem_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_ack", 32'(d_ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_word_kept", mem1[80], ref_mem[80]);
      chk("abort_ack_cnt", 32'(ack_cnt - a0), 32'd0);

      // request dropped one cycle after sampling still completes exactly once
      a0 = ack_cnt;
      push_exp(1'b1, 1'b0, 10'h060, 32'd0);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h060;
      @(posedge clk);
      @(negedge clk);
      d_req = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("drop_ack_count", 32'(ack_cnt - a0), 32'd1);

      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
